// File: rtl/cpu_io_arbiter_if.sv
// Bus bundle between the two host-side requesters, the shared cpu
// inport/outport and the tagged response channel of cpu_io_arbiter.
interface cpu_io_arbiter_if #(
    parameter int N = 8
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_x;
    logic [2*N-1:0] req_y;
    logic [N:0]     cpu_inport;
    logic [N-1:0]   cpu_outport;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [N-1:0]   rsp_x;
    logic [N-1:0]   rsp_y;
    logic           busy;

    // Arbiter side of the bundle.
    modport slave (
        input  req_valid, req_x, req_y, cpu_outport, rsp_ready,
        output req_ready, cpu_inport, rsp_valid, rsp_id, rsp_x, rsp_y, busy
    );

    // Requester / cpu / response-consumer side of the bundle.
    modport master (
        output req_valid, req_x, req_y, cpu_outport, rsp_ready,
        input  req_ready, cpu_inport, rsp_valid, rsp_id, rsp_x, rsp_y, busy
    );
endinterface

// File: rtl/cpu_io_arbiter.sv
// cpu_io_arbiter: shares one cpu between two requesters. A round-robin
// grant accepts an (x, y) pair, the pair is walked through the cpu inport
// handshake with fixed hold/gap timing, the two cpu outport results are
// sampled at fixed points and returned on a tagged valid/ready channel.
module cpu_io_arbiter #(
    parameter int n      = 8,
    parameter int HOLD   = 5,
    parameter int GAP    = 5,
    parameter int SETTLE = 20
) (
    input  logic            clk,
    input  logic            reset,
    cpu_io_arbiter_if.slave bus
);

    // One down-counter serves every timed state; it is sized for the
    // longest phase and holds "remaining cycles minus one".
    localparam int MAX_HG  = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAX_LEN = (MAX_HG > SETTLE) ? MAX_HG : SETTLE;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_X_HOLD = 3'd1,
        S_X_GAP  = 3'd2,
        S_Y_HOLD = 3'd3,
        S_Y_GAP  = 3'd4,
        S_R_HOLD = 3'd5,
        S_SETTLE = 3'd6,
        S_RESP   = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  x_q, x_d;
    logic [n-1:0]  y_q, y_d;
    logic          id_q, id_d;
    logic          last_grant_q, last_grant_d;
    logic [n-1:0]  rsp_x_q, rsp_x_d;
    logic [n-1:0]  rsp_y_q, rsp_y_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [n:0]    inport_q, inport_d;
    logic          busy_q, busy_d;

    logic          grant_s;
    logic [1:0]    req_ready_s;
    logic          last_s;
    logic [n-1:0]  gnt_x_s;
    logic [n-1:0]  gnt_y_s;

    // Round-robin pick: a lone valid wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_q;
            default: grant_s = 1'b0;
        endcase
    end

    // Operand mux for the granted requester.
    always_comb begin
        if (grant_s) begin
            gnt_x_s = bus.req_x[2*n-1:n];
            gnt_y_s = bus.req_y[2*n-1:n];
        end else begin
            gnt_x_s = bus.req_x[n-1:0];
            gnt_y_s = bus.req_y[n-1:0];
        end
    end

    assign last_s = (cnt_q == CNT_ZERO);

    // Next-state, counter reload, operand latching and result sampling.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        req_ready_s  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid[grant_s]) begin
                    req_ready_s  = grant_s ? 2'b10 : 2'b01;
                    x_d          = gnt_x_s;
                    y_d          = gnt_y_s;
                    id_d         = grant_s;
                    last_grant_d = grant_s;
                    cnt_d        = HOLD_LD;
                    state_d      = S_X_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_X_HOLD: begin
                if (last_s) begin
                    cnt_d   = GAP_LD;
                    state_d = S_X_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_X_GAP: begin
                if (last_s) begin
                    cnt_d   = HOLD_LD;
                    state_d = S_Y_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_Y_HOLD: begin
                if (last_s) begin
                    cnt_d   = GAP_LD;
                    state_d = S_Y_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_Y_GAP: begin
                // The cpu has had the whole gap to publish its first result.
                if (last_s) begin
                    rsp_x_d = bus.cpu_outport;
                    cnt_d   = HOLD_LD;
                    state_d = S_R_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_R_HOLD: begin
                // The extra ready phase prompts the cpu for its second result.
                if (last_s) begin
                    rsp_y_d = bus.cpu_outport;
                    cnt_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (last_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so the outputs can be registered.
    always_comb begin
        inport_d    = {(n+1){1'b0}};
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        case (state_d)
            S_X_HOLD: inport_d = {1'b1, x_d};
            S_X_GAP:  inport_d = {1'b0, x_d};
            S_Y_HOLD: inport_d = {1'b1, y_d};
            S_Y_GAP:  inport_d = {1'b0, y_d};
            S_R_HOLD: inport_d = {1'b1, y_d};
            S_SETTLE: inport_d = {1'b0, y_d};
            default:  inport_d = {(n+1){1'b0}};
        endcase
    end

    // State, counter and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= CNT_ZERO;
            x_q          <= {n{1'b0}};
            y_q          <= {n{1'b0}};
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_x_q      <= {n{1'b0}};
            rsp_y_q      <= {n{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
        end
    end

    // Registered outputs; the async clear drops the inport handshake at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inport_q    <= {(n+1){1'b0}};
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            inport_q    <= inport_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.cpu_inport = inport_q;
    assign bus.busy       = busy_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_x      = rsp_x_q;
    assign bus.rsp_y      = rsp_y_q;

endmodule

// File: doc/cpu_io_arbiter.md
Name: cpu_io_arbiter

Overview:
- Shares one picoNISC cpu between two requesters. Each requester submits (x, y) operand pairs.
- Arbitrates the requesters round-robin and drives the cpu inport handshake ({ready, data}) with fixed hold and gap timing.
- Samples the two cpu outport results and returns them on a shared valid/ready response channel, tagged with the requester id.
- Sits between the host-side requesters and the cpu inport/outport; the cpu program performs the affine transform.

Parameters:
- n, 8, data width of cpu inport data, cpu outport and operands.
- HOLD, 5, cycles ready is held high per handshake phase (>=1).
- GAP, 5, cycles ready is held low between phases (>=1).
- SETTLE, 20, idle cycles after the final phase before the result is presented (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester operand valid.
- req_ready  out  2  per-requester accept; transfer when valid && ready.
- req_x  in  2*n  operand x; requester i uses bits [i*n +: n].
- req_y  in  2*n  operand y; same packing as req_x.
- cpu_inport  out  n+1  {ready bit, data} to the cpu inport.
- cpu_outport  in  n  cpu outport.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  1  requester id owning the result.
- rsp_x  out  n  first sampled outport value (x2).
- rsp_y  out  n  second sampled outport value (y2).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async) values: state IDLE, cpu_inport 0, rsp_valid 0, rsp_id 0, rsp_x/rsp_y 0, busy 0, last_grant 1 (so requester 0 wins the first tie), counter 0.
- States: IDLE, X_HOLD, X_GAP, Y_HOLD, Y_GAP, R_HOLD, SETTLE, RESP. One down-counter reloads on each state entry.
- IDLE:
  - grant = the requester with valid set; if both are valid, grant = ~last_grant.
  - req_ready[grant] = req_valid[grant] (combinational, IDLE only); req_ready is 0 in all other states.
  - On accept: latch x, y and id; set last_grant = id; go to X_HOLD.
- cpu_inport by state:
  - X_HOLD {1,x} for HOLD cycles.
  - X_GAP {0,x} for GAP cycles.
  - Y_HOLD {1,y} for HOLD cycles.
  - Y_GAP {0,y} for GAP cycles. On the clock edge ending its last cycle, rsp_x <= cpu_outport.
  - R_HOLD {1,y} for HOLD cycles. On the edge ending its last cycle, rsp_y <= cpu_outport.
  - SETTLE {0,y} for SETTLE cycles.
  - RESP and IDLE: cpu_inport = 0.
- Latency: rsp_valid rises 3*HOLD + 2*GAP + SETTLE cycles after the accept edge (45 with defaults).
- RESP: rsp_valid=1; rsp_id, rsp_x and rsp_y are stable until rsp_valid && rsp_ready. On that edge, rsp_valid goes to 0 and the state returns to IDLE. A new accept is possible at the earliest on the following cycle.
- No back-pressure on the cpu side: the cpu must complete within the fixed timing.
- req_x/req_y changes after accept are ignored.
- Reset mid-operation: the transaction is abandoned with no response; cpu_inport drops to 0 immediately. A request still held valid is re-granted after reset release and runs the full sequence.
- All register widths are n; outport values are captured unmodified (two's complement passthrough).

Test Plan:
1. Single request, id0, x=8'h0A, y=8'hF8; stub cpu_outport=8'h17 at the Y_GAP sample and 8'hE1 at the R_HOLD sample.
   - cpu_inport must be 9'h10A x5, 9'h00A x5, 9'h1F8 x5, 9'h0F8 x5, 9'h1F8 x5, 9'h0F8 x20.
   - rsp_valid must rise 45 cycles after accept with rsp_id=0, rsp_x=8'h17, rsp_y=8'hE1.
2. Both req_valid high from reset:
   - id0 is served first, then id1.
   - Both high again: id0 is served (round-robin); each req_ready pulses exactly once per grant.
3. rsp_ready held low 10 cycles in RESP:
   - rsp_valid stays 1 with data stable; req_ready stays 00 despite pending valids.
   - Grant occurs only after the handshake.
4. reset asserted during Y_HOLD:
   - Same cycle: cpu_inport=0, busy=0, rsp_valid=0.
   - After release: the held request restarts from X_HOLD and completes normally.
5. Full system with cpu running the affine program (b0=20, b1=-20, a0=0.75, a1=0.5, a2=-0.5, a3=0.75):
   - (10,-8) -> (23.5, -31.0) within +/-1.
   - (-64,63) -> (3.5, 59.25) within +/-1.
6. HOLD=1, GAP=1, SETTLE=1: rsp_valid must rise 6 cycles after accept, and the inport sequence is scaled accordingly.
